// File: rtl/sound_scheduler.sv
// sound_scheduler: arbitrates the single buzzer tone generator between the
// held direction key, the pellet-eat chirp and the game-over melody.
// Fixed priority: game_over > eat > key. The eat chirp and the melody are
// timed multi-note sequences.
// Outputs are registered one stage behind the state register. An input
// sampled at edge N moves the state at edge N, and the outputs follow at
// edge N+1.
module sound_scheduler #(
  parameter int NOTE_TICKS = 12500000,
  parameter int EAT_TICKS  = 2500000,
  parameter int CNT_W      = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  num,
  input  logic        pressed,
  input  logic        eat,
  input  logic        game_over,
  output logic [14:0] frequency,
  output logic        tone_en,
  output logic        busy,
  output logic        over_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_EAT  = 3'd2,
    S_OVER = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] EAT_LAST  = CNT_W'(EAT_TICKS - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       note, note_next;
  logic [1:0]       num_q;

  logic [14:0] frequency_next;
  logic        tone_en_next;
  logic        busy_next;
  logic        over_done_next;

  // Half-period counts for the four direction keys.
  function automatic logic [14:0] key_tone(input logic [1:0] k);
    case (k)
      2'd0:    key_tone = 15'd25000;
      2'd1:    key_tone = 15'd12500;
      2'd2:    key_tone = 15'd8333;
      default: key_tone = 15'd6250;
    endcase
  endfunction

  // Two-note rising chirp played when a pellet is eaten.
  function automatic logic [14:0] chirp_tone(input logic [1:0] n);
    chirp_tone = (n == 2'd0) ? 15'd6250 : 15'd5000;
  endfunction

  // Four-note descending game-over melody.
  function automatic logic [14:0] melody_tone(input logic [1:0] n);
    case (n)
      2'd0:    melody_tone = 15'd8333;
      2'd1:    melody_tone = 15'd10000;
      2'd2:    melody_tone = 15'd12500;
      default: melody_tone = 15'd16667;
    endcase
  endfunction

  // State, tick counter, note index and the delayed key index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      note  <= 2'd0;
      num_q <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      note  <= note_next;
      num_q <= num;
    end
  end

  // Next-state logic, with the note timing for the chirp and the melody.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    note_next  = note;
    case (state)
      S_IDLE: begin
        if (game_over)    state_next = S_OVER;
        else if (eat)     state_next = S_EAT;
        else if (pressed) state_next = S_KEY;
      end
      S_KEY: begin
        if (game_over)     state_next = S_OVER;
        else if (eat)      state_next = S_EAT;
        else if (!pressed) state_next = S_IDLE;
      end
      S_EAT: begin
        if (game_over) begin
          state_next = S_OVER;
        end else if (eat) begin
          // A new pellet restarts the chirp from its first note.
          cnt_next  = '0;
          note_next = 2'd0;
        end else if (cnt == EAT_LAST) begin
          cnt_next = '0;
          if (note == 2'd1) state_next = pressed ? S_KEY : S_IDLE;
          else              note_next  = note + 2'd1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_OVER: begin
        // The melody cannot be interrupted; only the note timer matters here.
        if (cnt == NOTE_LAST) begin
          cnt_next = '0;
          if (note == 2'd3) state_next = S_HALT;
          else              note_next  = note + 2'd1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_HALT: begin
        if (!game_over) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Every state entry starts at the first tick of the first note.
    if (state_next != state) begin
      cnt_next  = '0;
      note_next = 2'd0;
    end
  end

  // Output decode from the present state (registered below).
  always_comb begin
    frequency_next = 15'd0;
    tone_en_next   = 1'b0;
    busy_next      = 1'b0;
    over_done_next = 1'b0;
    case (state)
      S_KEY: begin
        tone_en_next   = 1'b1;
        frequency_next = key_tone(num_q);
      end
      S_EAT: begin
        tone_en_next   = 1'b1;
        busy_next      = 1'b1;
        frequency_next = chirp_tone(note);
      end
      S_OVER: begin
        tone_en_next   = 1'b1;
        busy_next      = 1'b1;
        frequency_next = melody_tone(note);
      end
      S_HALT:  over_done_next = 1'b1;
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frequency <= 15'd0;
      tone_en   <= 1'b0;
      busy      <= 1'b0;
      over_done <= 1'b0;
    end else begin
      frequency <= frequency_next;
      tone_en   <= tone_en_next;
      busy      <= busy_next;
      over_done <= over_done_next;
    end
  end

endmodule

// File: tb/tb_sound_scheduler.sv
// Testbench for sound_scheduler. A queue-based reference model holds the
// remaining per-cycle tones of the active sequence. Every cycle the outputs
// are compared with the model, delayed by one register stage.
module tb_sound_scheduler;

  localparam int NT = 4;
  localparam int ET = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  num;
  logic        pressed;
  logic        eat;
  logic        game_over;
  logic [14:0] frequency;
  logic        tone_en;
  logic        busy;
  logic        over_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sound_scheduler #(.NOTE_TICKS(NT), .EAT_TICKS(ET), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .pressed(pressed), .eat(eat),
    .game_over(game_over), .frequency(frequency), .tone_en(tone_en),
    .busy(busy), .over_done(over_done)
  );

  // Reference model: the mode, plus the list of tones still to play.
  localparam int M_IDLE = 0, M_KEY = 1, M_EAT = 2, M_OVER = 3, M_HALT = 4;
  int          mode;
  int          q[$];
  logic [1:0]  m_num;
  int          key_tab[4] = '{25000, 12500, 8333, 6250};
  int          mel_tab[4] = '{8333, 10000, 12500, 16667};
  logic [14:0] exp_freq;
  logic        exp_en, exp_busy, exp_done;

  function automatic void load_chirp();
    q.delete();
    for (int i = 0; i < ET; i++) q.push_back(6250);
    for (int i = 0; i < ET; i++) q.push_back(5000);
  endfunction

  function automatic void load_melody();
    q.delete();
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < NT; i++) q.push_back(mel_tab[n]);
  endfunction

  function automatic void model_reset();
    mode = M_IDLE;
    q.delete();
    m_num = 2'd0;
    exp_freq = 15'd0; exp_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  function automatic void model_advance();
    exp_freq = 15'd0; exp_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
    case (mode)
      M_KEY: begin exp_en = 1'b1; exp_freq = 15'(key_tab[m_num]); end
      M_EAT, M_OVER: begin exp_en = 1'b1; exp_busy = 1'b1; exp_freq = 15'(q[0]); end
      M_HALT: exp_done = 1'b1;
      default: ;
    endcase
    case (mode)
      M_IDLE, M_KEY: begin
        if (game_over)                       begin mode = M_OVER; load_melody(); end
        else if (eat)                        begin mode = M_EAT;  load_chirp();  end
        else if (pressed)                    mode = M_KEY;
        else                                 mode = M_IDLE;
      end
      M_EAT: begin
        if (game_over)      begin mode = M_OVER; load_melody(); end
        else if (eat)       load_chirp();
        else begin
          void'(q.pop_front());
          if (q.size() == 0) mode = pressed ? M_KEY : M_IDLE;
        end
      end
      M_OVER: begin
        void'(q.pop_front());
        if (q.size() == 0) mode = M_HALT;
      end
      M_HALT: if (!game_over) mode = M_IDLE;
      default: mode = M_IDLE;
    endcase
    m_num = num;
  endfunction

  // Advance model and DUT one cycle; returns at the falling edge.
  task automatic cycle();
    model_advance();
    @(negedge clk);
  endtask

  function automatic string outs();
    return $sformatf("got freq=%0d en=%0b busy=%0b done=%0b, expected freq=%0d en=%0b busy=%0b done=%0b",
                     frequency, tone_en, busy, over_done, exp_freq, exp_en, exp_busy, exp_done);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; num = 2'd0; pressed = 1'b0; eat = 1'b0; game_over = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({frequency, tone_en, busy, over_done} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset: got %0d %b%b%b, expected all zero", frequency, tone_en, busy, over_done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL reset_idle cycle %0d: %s", i, outs());
      end
    end
  endtask

  task automatic test_key();
    pressed = 1'b1; num = 2'd2;
    for (int i = 0; i < 2; i++) begin
      cycle();
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL key_start cycle %0d: %s", i, outs());
      end
    end
    vectors++;
    if (frequency !== 15'd8333 || tone_en !== 1'b1) begin
      miscompares++; $display("FAIL key_num2: got freq=%0d en=%0b, expected 8333 1", frequency, tone_en);
    end
    num = 2'd0;
    cycle(); cycle();
    vectors++;
    if (frequency !== 15'd25000) begin
      miscompares++; $display("FAIL key_num0: got freq=%0d, expected 25000", frequency);
    end
    for (int i = 0; i < 12; i++) begin
      num = 2'($urandom_range(0, 3));
      cycle();
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL key_random cycle %0d: %s", i, outs());
      end
    end
    pressed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL key_release cycle %0d: %s", i, outs());
      end
    end
  endtask

  task automatic test_eat(input bit hold_key);
    int n_hi;
    int n_lo;
    n_hi = 0;
    n_lo = 0;
    pressed = hold_key; num = 2'd3;
    if (hold_key) begin cycle(); cycle(); end
    eat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      eat = 1'b0;
      if (frequency == 15'd6250 && busy) n_hi++;
      if (frequency == 15'd5000) n_lo++;
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL eat(key=%0b) cycle %0d: %s", hold_key, i, outs());
      end
    end
    vectors++;
    if (n_hi != ET || n_lo != ET) begin
      miscompares++; $display("FAIL eat_lengths: got %0d/%0d cycles, expected %0d/%0d", n_hi, n_lo, ET, ET);
    end
    pressed = 1'b0;
    cycle(); cycle();
  endtask

  task automatic test_eat_restart();
    eat = 1'b1; cycle(); eat = 1'b0;
    repeat ($urandom_range(1, 5)) cycle();
    eat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      eat = 1'b0;
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL eat_restart cycle %0d: %s", i, outs());
      end
    end
  endtask

  task automatic test_game_over();
    pressed = 1'b1; num = 2'd1;
    cycle(); cycle();
    game_over = 1'b1;
    for (int i = 0; i < 22; i++) begin
      cycle();
      eat = ($urandom_range(0, 3) == 0);
      num = 2'($urandom_range(0, 3));
      pressed = 1'($urandom_range(0, 1));
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL game_over cycle %0d: %s", i, outs());
      end
    end
    eat = 1'b0; pressed = 1'b0;
    vectors++;
    if (over_done !== 1'b1 || tone_en !== 1'b0) begin
      miscompares++; $display("FAIL halt_hold: got done=%0b en=%0b, expected 1 0", over_done, tone_en);
    end
    game_over = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL halt_exit cycle %0d: %s", i, outs());
      end
    end
  endtask

  task automatic test_over_pulse();
    int n_tone;
    int n_done;
    n_tone = 0;
    n_done = 0;
    game_over = 1'b1; eat = 1'b1;
    for (int i = 0; i < 22; i++) begin
      cycle();
      game_over = 1'b0; eat = 1'b0;
      if (tone_en) n_tone++;
      if (over_done) n_done++;
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL over_pulse cycle %0d: %s", i, outs());
      end
    end
    vectors++;
    if (n_tone != 4 * NT || n_done != 1) begin
      miscompares++; $display("FAIL over_pulse_len: got tone=%0d halt=%0d, expected %0d 1", n_tone, n_done, 4 * NT);
    end
  endtask

  task automatic test_async_reset();
    game_over = 1'b1;
    cycle();
    game_over = 1'b0;
    repeat (10) cycle();
    vectors++;
    if (frequency !== 15'd12500) begin
      miscompares++; $display("FAIL melody_note2: got freq=%0d, expected 12500", frequency);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({frequency, tone_en, busy, over_done} !== 18'd0) begin
      miscompares++; $display("FAIL async_reset: got %0d %b%b%b, expected all zero", frequency, tone_en, busy, over_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL after_reset cycle %0d: %s", i, outs());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) game_over = ~game_over;
      if ($urandom_range(0, 5) == 0) pressed = ~pressed;
      if ($urandom_range(0, 2) == 0) num = 2'($urandom_range(0, 3));
      eat = ($urandom_range(0, 7) == 0);
      cycle();
      vectors++;
      if ({frequency, tone_en, busy, over_done} !== {exp_freq, exp_en, exp_busy, exp_done}) begin
        miscompares++; $display("FAIL random cycle %0d: %s", i, outs());
      end
    end
    eat = 1'b0; pressed = 1'b0; game_over = 1'b0;
  endtask

  initial begin
    test_reset();
    test_key();
    test_eat(1'b0);
    test_eat(1'b1);
    test_eat_restart();
    test_game_over();
    test_over_pulse();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
- Sequences the single buzzer tone generator between three sound sources: held direction key, pellet-eat chirp, game-over melody.
- Sits between game logic and the tone generator.
- Outputs a half-period count (frequency), tone enable and status. The count uses the same encoding the tone generator already consumes.
- Fixed priority with timed multi-note sequences: game_over > eat > key.

Parameters:
- NOTE_TICKS, 12500000, cycles per game-over melody note (0.25 s at 50 MHz).
- EAT_TICKS, 2500000, cycles per eat-chirp note.
- CNT_W, 24, tick counter width; must hold max(NOTE_TICKS, EAT_TICKS)-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- num  in  2  direction key index 0..3.
- pressed  in  1  key held (level).
- eat  in  1  single-cycle pulse, pellet eaten.
- game_over  in  1  level, high while game over.
- frequency  out  15  half-period count to tone generator; 0 when silent.
- tone_en  out  1  tone generator enable.
- busy  out  1  high in EAT or OVER.
- over_done  out  1  high in HALT (melody finished).

Behaviour:
- All outputs registered; reset value 0 for every output, state=IDLE, tick counter=0, note index=0.
- Key table: num 0->25000, 1->12500, 2->8333, 3->6250.
- Eat chirp: 6250, then 5000.
- Melody: 8333, 10000, 12500, 16667 (descending pitch).
- States: IDLE, KEY, EAT, OVER, HALT.
- Latency: an input event sampled at edge N appears on outputs after edge N+1.
- IDLE:
  - frequency=0, tone_en=0.
  - game_over -> OVER; else eat -> EAT; else pressed -> KEY.
- KEY:
  - tone_en=1, frequency=table(num), updated every cycle while num changes.
  - !pressed -> IDLE; eat -> EAT; game_over -> OVER.
- EAT:
  - tone_en=1, busy=1; plays note 0 for EAT_TICKS cycles, then note 1 for EAT_TICKS cycles.
  - On completion: pressed -> KEY, else IDLE.
  - eat pulse during EAT restarts the chirp at note 0, counter 0.
  - Key changes are ignored until completion.
- OVER:
  - tone_en=1, busy=1; each melody note lasts NOTE_TICKS cycles.
  - Not preemptible; eat and pressed are ignored.
  - After note 3 completes -> HALT.
  - game_over dropping mid-melody does not abort; the melody finishes, then HALT exits immediately.
- HALT:
  - tone_en=0, frequency=0, busy=0, over_done=1.
  - Stays while game_over=1; game_over=0 -> IDLE.
- Entry from any non-OVER/HALT state: game_over takes effect on the next edge; counter and note index are cleared on every state entry.
- Tick counter counts 0..T-1; at T-1 it wraps to 0 and the note index advances. No partial notes and no off-by-one: each note is exactly T cycles of tone_en=1 with a stable frequency.
- Simultaneous eat and game_over: game_over wins; the eat pulse is dropped.
- Simultaneous eat and pressed in IDLE: EAT first, then KEY if still pressed.
- Reset asserted mid-sequence: immediate return to reset values regardless of state or clock.

Test Plan (NOTE_TICKS=4, EAT_TICKS=3):
- Reset, then pressed=1 num=2 -> tone_en=1 and frequency=8333 one cycle later. num->0 -> 25000 next cycle. pressed=0 -> frequency=0, tone_en=0.
- eat pulse in IDLE -> busy=1; frequency=6250 for 3 cycles, 5000 for 3 cycles; then IDLE, busy=0.
- pressed=1 num=3 held, eat pulse -> 6250 x3, 5000 x3, then back to 6250 (key 3) without a gap cycle.
- game_over=1 during KEY -> 8333, 10000, 12500, 16667, 4 cycles each. eat pulse and key changes during this have no effect. Then over_done=1, tone_en=0. game_over=0 -> over_done=0, IDLE.
- game_over pulsed for 1 cycle -> full 16-cycle melody plays, HALT lasts one cycle, then IDLE.
- rst_n low during melody note 2 -> all outputs 0 asynchronously (before next clk edge). After release with no inputs active, stays IDLE.
